// File: rtl/ahb_sram_slave_if.sv
// AHB-Lite bus bundle between a master/decoder and the SRAM responder.
interface ahb_sram_slave_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic        HRESP;
  logic [31:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_slave.sv
// AHB-Lite responder for a word-organised register-file memory with fixed
// wait states, little-endian byte lanes and a two-cycle ERROR response.
//
// state  | meaning
// S_IDLE | no transfer in progress, ready for an address phase
// S_WAIT | counting wait states, HREADYOUT low
// S_DATA | data phase completes at the next edge
// S_ERR1 | first error cycle, HREADYOUT low
// S_ERR2 | second error cycle, new address phase allowed
module ahb_sram_slave #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_STATES = 1
) (
  input logic              HCLK,
  input logic              HRESETn,
  ahb_sram_slave_if.slave  ahb
);

  localparam int         DEPTH    = 1 << (ADDR_W - 2);
  localparam logic [2:0] CNT_LOAD = 3'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

  state_t              state, state_d;
  logic [2:0]          cnt, cnt_d;
  logic [ADDR_W-1:0]   addr_q;
  logic                write_q;
  logic [2:0]          size_q;
  logic                take;
  logic [3:0]          lane_en;
  logic [31:0]         mem [DEPTH];

  logic accept, illegal;
  assign accept  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
  assign illegal = (ahb.HSIZE >= 3'd3) ||
                   ((ahb.HSIZE == 3'd1) && ahb.HADDR[0]) ||
                   ((ahb.HSIZE == 3'd2) && (ahb.HADDR[1:0] != 2'b00));

  // Upper address bits alias by design; HTRANS[0] does not change behaviour.
  logic unused_bits;
  assign unused_bits = ^{ahb.HADDR[31:ADDR_W], ahb.HTRANS[0]};

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      state <= S_IDLE;
      cnt   <= 3'd0;
    end else begin
      state <= state_d;
      cnt   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    take    = 1'b0;
    case (state)
      S_IDLE, S_DATA, S_ERR2: begin
        state_d = S_IDLE;
        if (accept) begin
          take = 1'b1;
          if (illegal) begin
            state_d = S_ERR1;
          end else if (WAIT_STATES == 0) begin
            state_d = S_DATA;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (cnt == 3'd0) state_d = S_DATA;
        else             cnt_d   = cnt - 3'd1;
      end
      S_ERR1:  state_d = S_ERR2;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      addr_q  <= '0;
      write_q <= 1'b0;
      size_q  <= 3'd0;
    end else if (take) begin
      addr_q  <= ahb.HADDR[ADDR_W-1:0];
      write_q <= ahb.HWRITE;
      size_q  <= ahb.HSIZE;
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (size_q)
      3'd0:    lane_en = 4'b0001 << addr_q[1:0];
      3'd1:    lane_en = addr_q[1] ? 4'b1100 : 4'b0011;
      3'd2:    lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // Memory is deliberately not reset; a reset edge still blocks the commit.
  always_ff @(posedge HCLK) begin
    if (HRESETn && (state == S_DATA) && write_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[addr_q[ADDR_W-1:2]][8*i +: 8] <= ahb.HWDATA[8*i +: 8];
      end
    end
  end

  assign ahb.HREADYOUT = (state != S_WAIT) && (state != S_ERR1);
  assign ahb.HRESP     = (state == S_ERR1) || (state == S_ERR2);
  assign ahb.HRDATA    = ((state == S_DATA) && !write_q) ? mem[addr_q[ADDR_W-1:2]] : 32'h0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench: three responders (WAIT_STATES 1, 0, 3) on one shared bus,
// read data checked against a queue of expected words.
module tb_ahb_sram_slave;
  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        hsel = 1'b0;
  logic [31:0] haddr = 32'h0;
  logic [1:0]  htrans = 2'b00;
  logic        hwrite = 1'b0;
  logic [2:0]  hsize = 3'd0;
  logic [31:0] hwdata = 32'h0;
  logic        hreadyout_m, hresp_m;
  logic [31:0] hrdata_m;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  always #5 HCLK = ~HCLK;

  ahb_sram_slave_if bus0();
  ahb_sram_slave_if bus1();
  ahb_sram_slave_if bus2();

  assign bus0.HSEL = hsel && (sel == 2'd0);
  assign bus1.HSEL = hsel && (sel == 2'd1);
  assign bus2.HSEL = hsel && (sel == 2'd2);
  assign {bus0.HADDR, bus1.HADDR, bus2.HADDR}    = {3{haddr}};
  assign {bus0.HTRANS, bus1.HTRANS, bus2.HTRANS} = {3{htrans}};
  assign {bus0.HWRITE, bus1.HWRITE, bus2.HWRITE} = {3{hwrite}};
  assign {bus0.HSIZE, bus1.HSIZE, bus2.HSIZE}    = {3{hsize}};
  assign {bus0.HWDATA, bus1.HWDATA, bus2.HWDATA} = {3{hwdata}};
  assign {bus0.HREADY, bus1.HREADY, bus2.HREADY} = {3{hreadyout_m}};

  assign hreadyout_m = (sel == 2'd0) ? bus0.HREADYOUT : (sel == 2'd1) ? bus1.HREADYOUT : bus2.HREADYOUT;
  assign hresp_m     = (sel == 2'd0) ? bus0.HRESP     : (sel == 2'd1) ? bus1.HRESP     : bus2.HRESP;
  assign hrdata_m    = (sel == 2'd0) ? bus0.HRDATA    : (sel == 2'd1) ? bus1.HRDATA    : bus2.HRDATA;

  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(1)) dut0 (.HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus0));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(0)) dut1 (.HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus1));
  ahb_sram_slave #(.ADDR_W(10), .WAIT_STATES(3)) dut2 (.HCLK(HCLK), .HRESETn(HRESETn), .ahb(bus2));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int ws_exp();
    case (sel)
      2'd0:    return 1;
      2'd1:    return 0;
      default: return 3;
    endcase
  endfunction

  task automatic pop_check(input string tag);
    logic [31:0] e;
    check({tag, "_sb_pending"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, hrdata_m, e);
    end
  endtask

  // Single non-pipelined OKAY transfer; expected read data goes on the queue.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [2:0] size, input logic [31:0] wdata, input logic [31:0] rexp);
    int waits = 0;
    bit done = 1'b0;
    hsel = 1'b1; htrans = 2'b10; hwrite = wr; haddr = addr; hsize = size;
    if (!wr) exp_q.push_back(rexp);
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    for (int c = 0; c < 20 && !done; c++) begin
      @(negedge HCLK);
      check({tag, "_hresp"}, 32'(hresp_m), 32'd0);
      if (hreadyout_m) begin
        done = 1'b1;
        if (wr) check({tag, "_hrdata_wr"}, hrdata_m, 32'h0);
        else    pop_check({tag, "_rdata"});
      end else begin
        waits++;
      end
      @(posedge HCLK); #1;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_waits"}, 32'(waits), 32'(ws_exp()));
  endtask

  task automatic err_xfer(input string tag, input logic [31:0] addr, input logic [2:0] size,
                          input logic [31:0] wdata);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = addr; hsize = size;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wdata;
    @(negedge HCLK);
    check({tag, "_e1_ready"}, 32'(hreadyout_m), 32'd0);
    check({tag, "_e1_resp"}, 32'(hresp_m), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check({tag, "_e2_ready"}, 32'(hreadyout_m), 32'd1);
    check({tag, "_e2_resp"}, 32'(hresp_m), 32'd1);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check({tag, "_after_resp"}, 32'(hresp_m), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset then idle
    sel = 2'd0;
    HRESETn = 1'b0;
    @(posedge HCLK); @(posedge HCLK); #1;
    HRESETn = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge HCLK);
      check("idle_ready", 32'(hreadyout_m), 32'd1);
      check("idle_resp", 32'(hresp_m), 32'd0);
      check("idle_rdata", hrdata_m, 32'h0);
      @(posedge HCLK); #1;
    end

    // word write/read, one wait state
    xfer("w10", 1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0);
    xfer("r10", 1'b0, 32'h0000_0010, 3'd2, 32'h0, 32'hDEAD_BEEF);

    // byte and halfword lanes, other lanes carry junk that must be ignored
    xfer("w20", 1'b1, 32'h0000_0020, 3'd2, 32'h1122_3344, 32'h0);
    xfer("wb21", 1'b1, 32'h0000_0021, 3'd0, 32'hAAAA_AAAA, 32'h0);
    xfer("wh22", 1'b1, 32'h0000_0022, 3'd1, 32'hBBCC_BBCC, 32'h0);
    xfer("r20", 1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'hBBCC_AA44);

    // alias: upper address bits ignored
    xfer("r20_alias", 1'b0, 32'hFFFF_FC20, 3'd2, 32'h0, 32'hBBCC_AA44);

    // errors leave memory untouched
    err_xfer("err_align", 32'h0000_0023, 3'd2, 32'hFFFF_FFFF);
    xfer("r20_post_align", 1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'hBBCC_AA44);
    err_xfer("err_size3", 32'h0000_0020, 3'd3, 32'hFFFF_FFFF);
    err_xfer("err_half_odd", 32'h0000_0021, 3'd1, 32'hFFFF_FFFF);
    xfer("r20_post_size", 1'b0, 32'h0000_0020, 3'd2, 32'h0, 32'hBBCC_AA44);

    // pipelined write then read, zero wait states
    sel = 2'd1;
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0040; hsize = 3'd2;
    @(posedge HCLK); #1;
    hwdata = 32'h0000_0055; hwrite = 1'b0;
    exp_q.push_back(32'h0000_0055);
    @(negedge HCLK);
    check("p_wr_ready", 32'(hreadyout_m), 32'd1);
    check("p_wr_rdata", hrdata_m, 32'h0);
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge HCLK);
    check("p_rd_ready", 32'(hreadyout_m), 32'd1);
    check("p_rd_resp", 32'(hresp_m), 32'd0);
    pop_check("p_rd_rdata");
    @(posedge HCLK); #1;
    @(negedge HCLK);
    check("p_after_rdata", hrdata_m, 32'h0);
    @(posedge HCLK); #1;

    // reset in the second wait cycle of a write, three wait states
    sel = 2'd2;
    xfer("w80_old", 1'b1, 32'h0000_0080, 3'd2, 32'hCAFE_F00D, 32'h0);
    hsel = 1'b1; htrans = 2'b10; hwrite = 1'b1; haddr = 32'h0000_0080; hsize = 3'd2;
    @(posedge HCLK); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'h1234_5678;
    @(negedge HCLK);
    check("rst_wait1_ready", 32'(hreadyout_m), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b0;
    @(negedge HCLK);
    check("rst_wait2_ready", 32'(hreadyout_m), 32'd0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    @(negedge HCLK);
    check("rst_after_ready", 32'(hreadyout_m), 32'd1);
    check("rst_after_resp", 32'(hresp_m), 32'd0);
    check("rst_after_rdata", hrdata_m, 32'h0);
    @(posedge HCLK); #1;
    repeat (5) @(posedge HCLK);
    #1;
    xfer("r80", 1'b0, 32'h0000_0080, 3'd2, 32'h0, 32'hCAFE_F00D);

    // memory survived the reset on the other responders too
    sel = 2'd0;
    xfer("r10_post_rst", 1'b0, 32'h0000_0010, 3'd2, 32'h0, 32'hDEAD_BEEF);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
